// File: rtl/maxpool_stream.sv
// ---------------------------------------------------------------------------
// maxpool_stream
//   Streaming 1-D max-pooling stage for conv2d feature samples. Each valid
//   input sample carries NUM_CHANNELS unsigned elements. Samples are grouped
//   into non-overlapping windows of POOL_SIZE samples. When a window closes,
//   the per-channel maximum over that window is emitted. A window closes
//   after POOL_SIZE samples, or early on a sample flagged frame_end.
//
// Parameters
//   DATA_WIDTH    unsigned width of one feature element
//   NUM_CHANNELS  channels per sample
//   POOL_SIZE     samples per window (2..16); stride equals POOL_SIZE
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   data_in         input sample; channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   data_valid      data_in valid this cycle
//   frame_end       last sample of frame (sampled only with data_valid)
//   data_out        pooled sample, same packing; held between pulses
//   data_out_valid  one-cycle pulse, registered one clock after the
//                   accepting edge
//   pool_count      outputs emitted since reset or the last frame_end;
//                   wraps 255 -> 0
// ---------------------------------------------------------------------------
module maxpool_stream #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_CHANNELS = 32,
    parameter int unsigned POOL_SIZE    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [DATA_WIDTH*NUM_CHANNELS-1:0] data_in,
    input  logic                               data_valid,
    input  logic                               frame_end,
    output logic [DATA_WIDTH*NUM_CHANNELS-1:0] data_out,
    output logic                               data_out_valid,
    output logic [7:0]                         pool_count
);

    localparam int unsigned BUS_W = DATA_WIDTH * NUM_CHANNELS;
    localparam int unsigned CNT_W = (POOL_SIZE > 2) ? $clog2(POOL_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POOL_SIZE - 1);

    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [BUS_W-1:0] max_q, max_d;
    logic [BUS_W-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic [7:0]       pool_cnt_q, pool_cnt_d;

    // Per-channel maximum including the current sample. At the start of a
    // window the stored value is stale, so the input is taken unconditionally.
    // A strict '>' keeps the stored value on ties.
    logic [BUS_W-1:0] cand;
    logic             close_win;

    always_comb begin
        cand = max_q;
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if ((win_cnt_q == '0) ||
                (data_in[c*DATA_WIDTH +: DATA_WIDTH] > max_q[c*DATA_WIDTH +: DATA_WIDTH])) begin
                cand[c*DATA_WIDTH +: DATA_WIDTH] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A frame_end on the last slot of a window takes the same single close
    // path as a full window, so it produces exactly one pulse.
    always_comb begin
        win_cnt_d  = win_cnt_q;
        max_d      = max_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        pool_cnt_d = pool_cnt_q;
        close_win  = 1'b0;
        if (data_valid) begin
            max_d     = cand;
            close_win = frame_end || (win_cnt_q == LAST_IDX);
            if (close_win) begin
                data_out_d = cand;
                valid_d    = 1'b1;
                win_cnt_d  = '0;
                pool_cnt_d = frame_end ? 8'd0 : pool_cnt_q + 8'd1;
            end else begin
                win_cnt_d = win_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q  <= '0;
            max_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            pool_cnt_q <= '0;
        end else begin
            win_cnt_q  <= win_cnt_d;
            max_q      <= max_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            pool_cnt_q <= pool_cnt_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign pool_count     = pool_cnt_q;

endmodule

// File: tb/tb_maxpool_stream.sv
// ---------------------------------------------------------------------------
// tb_maxpool_stream
//   Drives the same stream into two instances (POOL_SIZE=2 and POOL_SIZE=4).
//   A reference model keeps each window's raw samples and computes the max
//   when the window closes. Expected outputs are queued at drive time and
//   popped when the pulse is due. Table vectors and hand sequences add fixed
//   expectations for the POOL_SIZE=2 / POOL_SIZE=4 corner cases.
// ---------------------------------------------------------------------------
module tb_maxpool_stream;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 32;
    localparam int unsigned BW = DW * NC;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] din;
    logic          dv, fe;
    logic [BW-1:0] dout2, dout4;
    logic          ov2, ov4;
    logic [7:0]    pc2, pc4;

    always #5 clk = ~clk;

    maxpool_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .POOL_SIZE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv), .frame_end(fe),
        .data_out(dout2), .data_out_valid(ov2), .pool_count(pc2)
    );

    maxpool_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .POOL_SIZE(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .data_in(din), .data_valid(dv), .frame_end(fe),
        .data_out(dout4), .data_out_valid(ov4), .pool_count(pc4)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [7:0]    cnt;
    } exp_t;

    exp_t          sb2[$], sb4[$];
    logic [BW-1:0] win2[$], win4[$];
    logic [7:0]    cnt2, cnt4;
    logic [BW-1:0] last2, last4;
    logic          exp_p2, exp_p4;

    typedef struct {
        logic          v;
        logic          f;
        logic [DW-1:0] d0;
        logic          ev;
        logic [DW-1:0] e0;
        logic [7:0]    ec;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [BW-1:0] window_max(input logic [BW-1:0] w[$]);
        logic [BW-1:0] r = '0;
        foreach (w[i]) begin
            for (int unsigned c = 0; c < NC; c++) begin
                if (w[i][c*DW +: DW] > r[c*DW +: DW]) r[c*DW +: DW] = w[i][c*DW +: DW];
            end
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_bus(input int unsigned hi);
        logic [BW-1:0] r = '0;
        for (int unsigned c = 0; c < NC; c++) r[c*DW +: DW] = DW'($urandom_range(0, hi));
        return r;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [BW-1:0] d, input logic f);
        win2.push_back(d);
        if (win2.size() == 2 || f) begin
            cnt2 = f ? 8'd0 : cnt2 + 8'd1;
            sb2.push_back('{data: window_max(win2), cnt: cnt2});
            win2.delete();
            exp_p2 = 1'b1;
        end
        win4.push_back(d);
        if (win4.size() == 4 || f) begin
            cnt4 = f ? 8'd0 : cnt4 + 8'd1;
            sb4.push_back('{data: window_max(win4), cnt: cnt4});
            win4.delete();
            exp_p4 = 1'b1;
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        check("valid_p2", BW'(ov2), BW'(exp_p2));
        if (exp_p2) begin
            e = sb2.pop_front();
            check("data_p2", dout2, e.data);
            check("count_p2", BW'(pc2), BW'(e.cnt));
            last2 = e.data;
        end else begin
            check("hold_p2", dout2, last2);
            check("count_hold_p2", BW'(pc2), BW'(cnt2));
        end
        check("valid_p4", BW'(ov4), BW'(exp_p4));
        if (exp_p4) begin
            e = sb4.pop_front();
            check("data_p4", dout4, e.data);
            check("count_p4", BW'(pc4), BW'(e.cnt));
            last4 = e.data;
        end else begin
            check("hold_p4", dout4, last4);
            check("count_hold_p4", BW'(pc4), BW'(cnt4));
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 ns after the accepting edge.
    task automatic step(input logic [BW-1:0] d, input logic v, input logic f);
        din    = d;
        dv     = v;
        fe     = f;
        exp_p2 = 1'b0;
        exp_p4 = 1'b0;
        if (v) model_accept(d, f);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        dv    = 1'b0;
        fe    = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_dout2", dout2, '0);
        check("rst_valid2", BW'(ov2), '0);
        check("rst_count2", BW'(pc2), '0);
        check("rst_dout4", dout4, '0);
        check("rst_valid4", BW'(ov4), '0);
        check("rst_count4", BW'(pc4), '0);
        win2.delete(); win4.delete();
        sb2.delete();  sb4.delete();
        cnt2 = '0; cnt4 = '0;
        last2 = '0; last4 = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [BW-1:0] pa, pb, pm;
        int            pulses;

        din = '0;
        tbl[0] = '{v: 1'b1, f: 1'b0, d0: 16'd5, ev: 1'b0, e0: 16'd0, ec: 8'd0};
        tbl[1] = '{v: 1'b1, f: 1'b0, d0: 16'd9, ev: 1'b1, e0: 16'd9, ec: 8'd1};
        tbl[2] = '{v: 1'b1, f: 1'b0, d0: 16'd7, ev: 1'b0, e0: 16'd9, ec: 8'd1};
        tbl[3] = '{v: 1'b0, f: 1'b0, d0: 16'd0, ev: 1'b0, e0: 16'd9, ec: 8'd1};
        tbl[4] = '{v: 1'b0, f: 1'b1, d0: 16'd0, ev: 1'b0, e0: 16'd9, ec: 8'd1};
        tbl[5] = '{v: 1'b0, f: 1'b0, d0: 16'd0, ev: 1'b0, e0: 16'd9, ec: 8'd1};
        tbl[6] = '{v: 1'b1, f: 1'b0, d0: 16'd3, ev: 1'b1, e0: 16'd7, ec: 8'd2};
        tbl[7] = '{v: 1'b1, f: 1'b0, d0: 16'd4, ev: 1'b0, e0: 16'd7, ec: 8'd2};
        tbl[8] = '{v: 1'b1, f: 1'b1, d0: 16'd6, ev: 1'b1, e0: 16'd6, ec: 8'd0};
        tbl[9] = '{v: 1'b1, f: 1'b1, d0: 16'd2, ev: 1'b1, e0: 16'd2, ec: 8'd0};

        do_reset();

        // POOL_SIZE=2: 5,9 pair; 7 then a gap (frame_end ignored while idle)
        // then 3; frame_end on the last slot; frame_end on a lone sample.
        for (int i = 0; i < 10; i++) begin
            step(BW'(tbl[i].d0), tbl[i].v, tbl[i].f);
            check("tbl_valid", BW'(ov2), BW'(tbl[i].ev));
            check("tbl_data", dout2, BW'(tbl[i].e0));
            check("tbl_count", BW'(pc2), BW'(tbl[i].ec));
        end

        // POOL_SIZE=4 partial window closed by frame_end, then a fresh window.
        step(BW'(16'd1), 1'b1, 1'b0);
        step(BW'(16'd8), 1'b1, 1'b1);
        check("p4_fe_valid", BW'(ov4), BW'(1));
        check("p4_fe_data", dout4, BW'(16'd8));
        check("p4_fe_count", BW'(pc4), '0);
        step(BW'(16'd3), 1'b1, 1'b0);
        step(BW'(16'd2), 1'b1, 1'b0);
        step(BW'(16'd6), 1'b1, 1'b0);
        step(BW'(16'd1), 1'b1, 1'b0);
        check("p4_new_valid", BW'(ov4), BW'(1));
        check("p4_new_data", dout4, BW'(16'd6));
        check("p4_new_count", BW'(pc4), BW'(1));

        // All ones then all zeros.
        step('1, 1'b1, 1'b0);
        step('0, 1'b1, 1'b0);
        check("ones_valid", BW'(ov2), BW'(1));
        check("ones_data", dout2, '1);

        // Per-channel distinct values: upper channels win from pa, lower from pb.
        pa = '0; pb = '0; pm = '0;
        for (int unsigned c = 0; c < NC; c++) begin
            pa[c*DW +: DW] = DW'(c * 16'h0800 + 1);
            pb[c*DW +: DW] = DW'((NC - 1 - c) * 16'h0800 + 2);
            pm[c*DW +: DW] = (c >= NC / 2) ? pa[c*DW +: DW] : pb[c*DW +: DW];
        end
        step(pa, 1'b1, 1'b0);
        step(pb, 1'b1, 1'b0);
        check("chan_pack", dout2, pm);

        // Random traffic with gaps, frame ends and frequent ties.
        for (int i = 0; i < 60; i++) begin
            step(rand_bus((i % 2 == 0) ? 3 : 16'hFFFF), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0);
        end

        // Reset mid-window: the pre-reset 50 must not leak into the next window.
        do_reset();
        step(BW'(16'd50), 1'b1, 1'b0);
        do_reset();
        step(BW'(16'd4), 1'b1, 1'b0);
        check("rst_first_valid", BW'(ov2), '0);
        step(BW'(16'd2), 1'b1, 1'b0);
        check("rst_win_valid", BW'(ov2), BW'(1));
        check("rst_win_data", dout2, BW'(16'd4));
        check("rst_win_count", BW'(pc2), BW'(1));

        // 512 back-to-back samples: 256 pulses on POOL_SIZE=2, counter wraps.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 512; i++) begin
            step(rand_bus(16'hFFFF), 1'b1, 1'b0);
            if (ov2) pulses++;
        end
        check("wrap_pulses", BW'(pulses), BW'(256));
        check("wrap_count2", BW'(pc2), '0);
        check("wrap_count4", BW'(pc4), BW'(128));

        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check("sb2_drained", BW'(sb2.size()), '0);
        check("sb4_drained", BW'(sb4.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning unsigned width of one feature element.
REQ-002 SHALL have parameter NUM_CHANNELS, default 32, meaning number of filter channels per input sample.
REQ-003 SHALL have parameter POOL_SIZE, default 2, meaning samples per pooling window (legal range 2..16); stride equals POOL_SIZE (non-overlapping windows).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic SHALL be rising-edge triggered.
REQ-005 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 SHALL have port data_in, input, DATA_WIDTH*NUM_CHANNELS, meaning one sample of conv2d feature output; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port data_valid, input, 1, meaning data_in is valid this cycle.
REQ-008 SHALL have port frame_end, input, 1, meaning the current valid sample is the last of its frame; it is sampled only when data_valid=1.
REQ-009 SHALL have port data_out, output reg, DATA_WIDTH*NUM_CHANNELS, meaning pooled sample, same channel packing as data_in.
REQ-010 SHALL have port data_out_valid, output reg, 1, meaning one-cycle pulse marking data_out valid.
REQ-011 SHALL have port pool_count, output reg, 8, meaning number of pooled samples emitted since reset or last frame_end, wrapping at 255->0.

Function
REQ-012 SHALL keep a window counter win_cnt (0..POOL_SIZE-1) and one running-max register per channel.
REQ-013 SHALL, on data_valid with win_cnt=0, load running max with data_in (per channel, no comparison against old value).
REQ-014 SHALL, on data_valid with win_cnt>0, update each channel's running max to the unsigned maximum of the stored value and data_in; ties keep the stored value (numerically identical).
REQ-015 SHALL, on data_valid with win_cnt=POOL_SIZE-1, drive data_out with the final per-channel maximum (including the current sample) and pulse data_out_valid for exactly one cycle, registered one clock after the accepting edge; win_cnt SHALL return to 0.
REQ-016 SHALL, on data_valid with frame_end=1 at any win_cnt, close the window: emit the partial-window maximum as in REQ-015, reset win_cnt to 0 and pool_count to 0 in the same edge.
REQ-017 SHALL, on frame_end=1 with win_cnt=POOL_SIZE-1, emit exactly one output (no double pulse).
REQ-018 SHALL ignore frame_end when data_valid=0.
REQ-019 SHALL hold win_cnt, running max, data_out and pool_count unchanged on cycles with data_valid=0; data_out_valid SHALL be 0 on every cycle not specified by REQ-015/REQ-016.
REQ-020 SHALL keep data_out stable between pulses (last emitted value held).
REQ-021 SHALL increment pool_count by 1 with each emitted output not caused by frame_end, wrapping 255->0.
REQ-022 SHALL accept back-to-back data_valid every cycle with no stall; throughput one input sample per clock.
REQ-023 SHALL perform no arithmetic beyond unsigned comparison; output width equals input width, no saturation needed.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear data_out, data_out_valid, pool_count, win_cnt and all running-max registers to 0.
REQ-025 SHALL, on reset asserted mid-window, discard the partial window; no output is emitted for it after reset release.
REQ-026 SHALL accept a valid sample on the first rising edge after rst_n deasserts, treating it as win_cnt=0.

Verification
REQ-027 SHALL cover: POOL_SIZE=2, channel0 inputs 5 then 9 on consecutive cycles -> one pulse, channel0 out=9, pool_count=1.
REQ-028 SHALL cover: channel0 inputs 7, gap of 3 invalid cycles, then 3 -> single pulse after the 3, out=7; data_out_valid low during gap.
REQ-029 SHALL cover: POOL_SIZE=4, inputs 1,8 with frame_end on the 8 -> pulse out=8, pool_count=0, next input starts new window.
REQ-030 SHALL cover: all channels 0xFFFF then 0x0000 -> out all 0xFFFF; distinct per-channel values verify channel packing and independence.
REQ-031 SHALL cover: rst_n pulsed low after first sample of a window -> all outputs 0, next two samples 4,2 -> out=4 (pre-reset sample excluded).
REQ-032 SHALL cover: 512 continuous valid samples with POOL_SIZE=2 -> 256 pulses, pool_count wraps to 0, one pulse per 2 cycles.
